imm_inst_encoder: RTL and testbench

//  Inverse of the decode-stage immediate generator: packs opcode, register fields, funct

---
 rtl/imm_inst_encoder_if.sv | 34 +++
 rtl/imm_inst_encoder.sv | 183 ++++++++++++++++++
 tb/tb_imm_inst_encoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/imm_inst_encoder_if.sv
// Request/response bus of the RV32I immediate instruction encoder.
// slave  : the encoder side (accepts fields, produces the packed word).
// master : the producer/consumer side (drives fields and out_ready).
interface imm_inst_encoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_type;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [2:0]           in_funct3;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [6:0]           in_funct7;
  logic [31:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_inst;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  in_valid, in_type, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_cnt
  );

  modport master (
    output in_valid, in_type, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_cnt
  );
endinterface

// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder: packs opcode, register/funct fields and a 32-bit immediate
// into one RV32I instruction word (inverse of the decode immediate generator).
// Two-stage valid/ready pipeline: stage 1 holds the accepted fields, stage 2
// holds the packed word. Optional macro IMM_ENC_RANGE_CHECK_EN adds the
// immediate range checker, out_err and the saturating error counter; without
// it out_err and err_cnt are constant zero.
module imm_inst_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_inst_encoder_if.slave  bus
);

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;

  // Scatter the immediate and fields into the instruction word; unused fields stay zero.
  function automatic logic [31:0] pack_inst(
    input logic [2:0]  typ,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [2:0]  f3,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (typ)
      T_R:     w = {f7, rs2, rs1, f3, rd, op};
      T_I:     w = {imm[11:0], rs1, f3, rd, op};
      T_S:     w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      T_B:     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      T_U:     w = {imm[31:12], rd, op};
      T_J:     w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

`ifdef IMM_ENC_RANGE_CHECK_EN
  // Sign-extension checks: a value fits N signed bits when bits [31:N-1] all agree.
  function automatic logic range_err(input logic [2:0] typ, input logic [31:0] imm);
    logic e;
    case (typ)
      T_R:      e = 1'b0;
      T_I, T_S: e = !((&imm[31:11]) || !(|imm[31:11]));
      T_B:      e = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      T_U:      e = |imm[11:0];
      T_J:      e = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      default:  e = 1'b1;
    endcase
    return e;
  endfunction
`endif

  logic        s1_v_q, s1_v_d;
  logic [2:0]  s1_type_q;
  logic [6:0]  s1_op_q;
  logic [4:0]  s1_rd_q;
  logic [2:0]  s1_f3_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [6:0]  s1_f7_q;
  logic [31:0] s1_imm_q;
  logic        s2_v_q, s2_v_d;
  logic [31:0] out_inst_q;
  logic        in_accept;
  logic        s2_load;
  logic        s1_adv;
  logic        in_ready_c;

  // Handshake and pipeline-advance decisions; in_ready looks through a draining stage 2.
  always_comb begin
    s2_load    = s1_v_q && (!s2_v_q || bus.out_ready);
    s1_adv     = s2_load;
    in_ready_c = !s1_v_q || s1_adv;
    in_accept  = bus.in_valid && in_ready_c;
    if (in_accept) begin
      s1_v_d = 1'b1;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end
    if (s2_load) begin
      s2_v_d = 1'b1;
    end else if (bus.out_ready) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Stage 1: capture the accepted request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_type_q <= 3'd0;
      s1_op_q   <= 7'd0;
      s1_rd_q   <= 5'd0;
      s1_f3_q   <= 3'd0;
      s1_rs1_q  <= 5'd0;
      s1_rs2_q  <= 5'd0;
      s1_f7_q   <= 7'd0;
      s1_imm_q  <= 32'd0;
    end else begin
      s1_v_q <= s1_v_d;
      if (in_accept) begin
        s1_type_q <= bus.in_type;
        s1_op_q   <= bus.in_opcode;
        s1_rd_q   <= bus.in_rd;
        s1_f3_q   <= bus.in_funct3;
        s1_rs1_q  <= bus.in_rs1;
        s1_rs2_q  <= bus.in_rs2;
        s1_f7_q   <= bus.in_funct7;
        s1_imm_q  <= bus.in_imm;
      end
    end
  end

  // Stage 2: register the packed word; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q     <= 1'b0;
      out_inst_q <= 32'd0;
    end else begin
      s2_v_q <= s2_v_d;
      if (s2_load) begin
        out_inst_q <= pack_inst(s1_type_q, s1_op_q, s1_rd_q, s1_f3_q,
                                s1_rs1_q, s1_rs2_q, s1_f7_q, s1_imm_q);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_v_q;
  assign bus.out_inst  = out_inst_q;

`ifdef IMM_ENC_RANGE_CHECK_EN
  logic                 s1_err_q;
  logic                 out_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of delivered erroneous words.
  always_comb begin
    if (s2_v_q && bus.out_ready && out_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Range-check result travels alongside the fields and the packed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q  <= 1'b0;
      out_err_q <= 1'b0;
      err_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      err_cnt_q <= err_cnt_d;
      if (in_accept) begin
        s1_err_q <= range_err(bus.in_type, bus.in_imm);
      end
      if (s2_load) begin
        out_err_q <= s1_err_q;
      end
    end
  end

  assign bus.out_err = out_err_q;
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.out_err = 1'b0;
  assign bus.err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Directed self-checking bench for imm_inst_encoder: packing per type, latency,
// error flag/counter, back-pressure with ordering, and reset mid-flight.
module tb_imm_inst_encoder;

`ifdef IMM_ENC_RANGE_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  imm_inst_encoder_if #(.ERR_CNT_W(8)) bus ();

  imm_inst_encoder #(.ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        bad;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    bus.in_type   = v.typ;
    bus.in_opcode = v.op;
    bus.in_rd     = v.rd;
    bus.in_funct3 = v.f3;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
    bus.in_valid  = 1'b1;
  endtask

  // One transaction through an empty pipeline, checking 2-cycle latency and result.
  task automatic send_check(input int idx, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    drive_vec(vecs[idx]);
    bus.out_ready = 1'b1;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_accept"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_eq({tag, "_inst"}, bus.out_inst, vecs[idx].exp_inst);
    check_eq({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, EN & vecs[idx].bad});
  endtask

  initial begin
    int acc;
    int nout;
    bit take;
    //           typ   op     rd    f3    rs1   rs2   f7     imm            exp_inst       bad
    vecs[0]  = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0005, 32'h0050_0093, 1'b0};
    vecs[1]  = '{3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0};
    vecs[2]  = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[3]  = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    vecs[4]  = '{3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0};
    vecs[5]  = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    vecs[6]  = '{3'd5, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
    vecs[7]  = '{3'd1, 7'h13, 5'd2, 3'd0, 5'd3, 5'd0, 7'h00, 32'hFFFF_F800, 32'h8001_8113, 1'b0};
    vecs[8]  = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0003, 32'h0000_0163, 1'b1};
    vecs[9]  = '{3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1};
    vecs[10] = '{3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0005, 32'h0000_0000, 1'b1};

    bus.in_valid = 1'b0; bus.in_type = 3'd0; bus.in_opcode = 7'd0; bus.in_rd = 5'd0;
    bus.in_funct3 = 3'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_funct7 = 7'd0;
    bus.in_imm = 32'd0; bus.out_ready = 1'b0;

    // reset state
    #1;
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_out_inst", bus.out_inst, 32'd0);
    check_eq("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    check_eq("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // packing of every type, including boundaries and error cases
    for (int i = 0; i <= 10; i++) send_check(i, $sformatf("vec%0d", i));
    @(negedge clk);
    check_eq("err_cnt_after_errs", {24'd0, bus.err_cnt}, EN ? 32'd3 : 32'd0);

    // back-pressure: consumer stalls for 6 cycles while 4 words are offered
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) drive_vec(vecs[acc]); else bus.in_valid = 1'b0;
      #1;
      take = bus.in_ready && (acc < 4);
      @(posedge clk);
      if (take) acc++;
      @(negedge clk);
    end
    check_eq("bp_accepted", acc, 32'd2);
    check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("bp_held_inst", bus.out_inst, vecs[0].exp_inst);

    // release: all 4 words must emerge in order
    bus.out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 30 && nout < 4; c++) begin
      if (bus.out_valid) begin
        check_eq($sformatf("bp_out%0d", nout), bus.out_inst, vecs[nout].exp_inst);
        nout++;
      end
      if (acc < 4) drive_vec(vecs[acc]); else bus.in_valid = 1'b0;
      #1;
      take = bus.in_ready && (acc < 4);
      @(posedge clk);
      if (take) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_eq("bp_total_out", nout, 32'd4);
    check_eq("bp_total_acc", acc, 32'd4);
    check_eq("bp_no_extra", {31'd0, bus.out_valid}, 32'd0);

    // reset with two words in flight
    @(negedge clk);
    drive_vec(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    drive_vec(vecs[1]);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("midrst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_no_ghost", {31'd0, bus.out_valid}, 32'd0);
    send_check(2, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
